// File: rtl/vga_pkg.sv
// Shared VGA scanout definitions: default 640x480@60 geometry, coordinate and
// pixel types, and the VRAM address packing used by both read and write paths.
package vga_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned ADDR_W  = 2 * COORD_W;

    localparam int unsigned CLK_DIV_DEF  = 4;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [PIX_W-1:0]   rgb332_t;

    typedef struct packed {
        coord_t y;
        coord_t x;
    } vram_addr_t;

    // Row-major {y, x} packing, identical on the GPU write side.
    function automatic vram_addr_t pack_addr(input coord_t y, input coord_t x);
        return vram_addr_t'({y, x});
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// VRAM read port between the scanout engine (master) and the shared VRAM (slave).
interface vga_scanout_if;
    import vga_pkg::*;

    vram_addr_t vram_rd_addr;
    logic       vram_rd_en;
    rgb332_t    vram_rd_data;

    modport master (
        output vram_rd_addr,
        output vram_rd_en,
        input  vram_rd_data
    );

    modport slave (
        input  vram_rd_addr,
        input  vram_rd_en,
        output vram_rd_data
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel-clock divider plus horizontal/vertical raster counters and their
// active-area and sync-window decodes.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV      = CLK_DIV_DEF,
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned H_SYNC_END   = H_SYNC_END_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
    parameter int unsigned V_SYNC_END   = V_SYNC_END_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t h,
    output coord_t v,
    output logic   tick_c,
    output logic   pix_start_c,
    output logic   active_c,
    output logic   hsync_win_c,
    output logic   vsync_win_c
);

    coord_t div;

    assign tick_c      = (div == COORD_W'(CLK_DIV - 1));
    assign pix_start_c = (div == '0);
    assign active_c    = (h < COORD_W'(H_ACTIVE)) && (v < COORD_W'(V_ACTIVE));
    assign hsync_win_c = (h >= COORD_W'(H_SYNC_START)) && (h <= COORD_W'(H_SYNC_END));
    assign vsync_win_c = (v >= COORD_W'(V_SYNC_START)) && (v <= COORD_W'(V_SYNC_END));

    // Disabling restarts the raster at (0,0); a partial frame is never resumed.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (tick_c) begin
            div <= '0;
            if (h == COORD_W'(H_TOTAL - 1)) begin
                h <= '0;
                v <= (v == COORD_W'(V_TOTAL - 1)) ? '0 : v + COORD_W'(1);
            end else begin
                h <= h + COORD_W'(1);
            end
        end else begin
            div <= div + COORD_W'(1);
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: fetches one VRAM pixel per active position and presents
// registered colour, syncs, data-enable and frame marker on the pixel tick.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    vga_scanout_if.master        vram,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_de,
    output rgb332_t              vga_rgb,
    output logic                 frame_start
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    coord_t h;
    coord_t v;
    logic   tick_c;
    logic   pix_start_c;
    logic   active_c;
    logic   hsync_win_c;
    logic   vsync_win_c;

    vga_timing #(
        .CLK_DIV      (CLK_DIV),
        .H_ACTIVE     (H_ACTIVE),
        .H_TOTAL      (H_TOTAL),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_END   (H_SYNC_END),
        .V_ACTIVE     (V_ACTIVE),
        .V_TOTAL      (V_TOTAL),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_END   (V_SYNC_END)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .h           (h),
        .v           (v),
        .tick_c      (tick_c),
        .pix_start_c (pix_start_c),
        .active_c    (active_c),
        .hsync_win_c (hsync_win_c),
        .vsync_win_c (vsync_win_c)
    );

    // Read on the first clk of each pixel so data settles before the capturing tick.
    assign vram.vram_rd_en   = en && active_c && pix_start_c;
    assign vram.vram_rd_addr = active_c ? pack_addr(v, h) : '0;

    // Output stage lags the counters by one pixel tick.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            vga_hsync   <= ~HSYNC_POL;
            vga_vsync   <= ~VSYNC_POL;
            vga_de      <= 1'b0;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick_c && (h == '0) && (v == '0);
            if (tick_c) begin
                vga_de    <= active_c;
                vga_rgb   <= active_c ? vram.vram_rd_data : '0;
                vga_hsync <= hsync_win_c ? HSYNC_POL : ~HSYNC_POL;
                vga_vsync <= vsync_win_c ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized en/reset disturbance bench for vga_scanout on a reduced raster,
// checked against a position-from-elapsed-clocks reference model.
module tb_vga_scanout;

    localparam int unsigned DIV = 4;
    localparam int unsigned HA = 20, HF = 3, HS = 4, HB = 3;
    localparam int unsigned VA = 8,  VF = 2, VS = 2, VB = 2;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME_CLKS = HT * VT * DIV;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_de;
    logic [7:0] vga_rgb;
    logic       frame_start;
    logic       inject_ff;

    int unsigned edge_cnt;
    int unsigned n_checks;
    int unsigned n_fail;

    vga_scanout_if vram_bus();

    vga_scanout #(
        .CLK_DIV   (DIV),
        .H_ACTIVE  (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE  (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .vram        (vram_bus.master),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_de      (vga_de),
        .vga_rgb     (vga_rgb),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] vram_fn(input logic [19:0] a);
        return a[7:0] ^ a[17:10];
    endfunction

    // VRAM: 1-clk read latency, data held between strobes; 0xFF while blanking.
    always @(posedge clk) begin
        if (vram_bus.vram_rd_en)
            vram_bus.vram_rd_data <= vram_fn(20'(vram_bus.vram_rd_addr));
        else if (inject_ff)
            vram_bus.vram_rd_data <= 8'hFF;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (clk %0d since restart)", tag, got, exp, edge_cnt);
        end
    endtask

    // Expected state from clocks elapsed since the last reset/enable restart.
    task automatic check_all();
        int unsigned p, d, hp, vp, q, h, v;
        logic        act, de_e, hs_e, vs_e, fs_e;
        logic [7:0]  rgb_e;
        p  = edge_cnt / DIV;
        d  = edge_cnt % DIV;
        hp = p % HT;
        vp = (p / HT) % VT;
        act = (hp < HA) && (vp < VA);
        check_eq("rd_en", 32'(vram_bus.vram_rd_en), 32'(en && act && (d == 0)));
        check_eq("rd_addr", 32'(vram_bus.vram_rd_addr), act ? ((vp << 10) | hp) : 32'd0);
        if (edge_cnt < DIV) begin
            de_e = 1'b0; rgb_e = 8'h00; hs_e = 1'b1; vs_e = 1'b1; fs_e = 1'b0;
        end else begin
            q = edge_cnt / DIV - 1;
            h = q % HT;
            v = (q / HT) % VT;
            de_e  = (h < HA) && (v < VA);
            rgb_e = de_e ? 8'((h ^ v) & 32'hFF) : 8'h00;
            hs_e  = !((h >= HA + HF) && (h < HA + HF + HS));
            vs_e  = !((v >= VA + VF) && (v < VA + VF + VS));
            fs_e  = (d == 0) && (h == 0) && (v == 0);
        end
        check_eq("de", 32'(vga_de), 32'(de_e));
        check_eq("rgb", 32'(vga_rgb), 32'(rgb_e));
        check_eq("hsync", 32'(vga_hsync), 32'(hs_e));
        check_eq("vsync", 32'(vga_vsync), 32'(vs_e));
        check_eq("frame_start", 32'(frame_start), 32'(fs_e));
    endtask

    // One clk: advance model, optional rst_n glitch between edges, then drive and check.
    task automatic cycle(input logic nen, input logic nrst, input bit glitch);
        int unsigned p;
        @(posedge clk);
        if (!rst_n || !en) edge_cnt = 0;
        else               edge_cnt++;
        if (glitch) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
        end
        @(negedge clk);
        en    = nen;
        rst_n = nrst;
        p = edge_cnt / DIV;
        inject_ff = !(((p % HT) < HA) && (((p / HT) % VT) < VA));
        #1 check_all();
    endtask

    task automatic run(input int unsigned n);
        repeat (n) cycle(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        int unsigned len;
        rst_n     = 1'b0;
        en        = 1'b1;
        inject_ff = 1'b0;
        edge_cnt  = 0;
        n_checks  = 0;
        n_fail    = 0;

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        run(FRAME_CLKS + 120);

        for (int k = 0; k < 10; k++) begin
            run($urandom_range(20, 1800));
            case ($urandom_range(0, 3))
                0: begin
                    len = $urandom_range(1, 4);
                    repeat (len) cycle(1'b0, 1'b1, 1'b0);
                    cycle(1'b1, 1'b1, 1'b0);
                end
                1: begin
                    cycle(1'b1, 1'b0, 1'b0);
                    cycle(1'b1, 1'b1, 1'b0);
                end
                2: cycle(1'b1, 1'b1, 1'b1);
                default: begin
                    cycle(1'b0, 1'b0, 1'b0);
                    cycle(1'b1, 1'b1, 1'b0);
                end
            endcase
        end

        run(2 * FRAME_CLKS + 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
